// File: rtl/calc_disp_pkg.sv
// rtl/calc_disp_pkg.sv - glyph codes, segment constants and slot type for the calculator display
package calc_disp_pkg;

  typedef enum logic [3:0] {
    DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7, DIG8, DIG9,
    MINUS, E, R, BLANK
  } glyph_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [1:0] slot_t;

endpackage

// File: rtl/calc_glyph_rom.sv
// rtl/calc_glyph_rom.sv - combinational glyph to active-low seven-segment decoder
module calc_glyph_rom
  import calc_disp_pkg::*;
(
  input  glyph_e     glyph_i,
  output logic [6:0] sseg_o
);

  always_comb begin
    sseg_o = SEG_BLANK;
    case (glyph_i)
      DIG0:    sseg_o = SEG_0;
      DIG1:    sseg_o = SEG_1;
      DIG2:    sseg_o = SEG_2;
      DIG3:    sseg_o = SEG_3;
      DIG4:    sseg_o = SEG_4;
      DIG5:    sseg_o = SEG_5;
      DIG6:    sseg_o = SEG_6;
      DIG7:    sseg_o = SEG_7;
      DIG8:    sseg_o = SEG_8;
      DIG9:    sseg_o = SEG_9;
      MINUS:   sseg_o = SEG_MINUS;
      E:       sseg_o = SEG_E;
      R:       sseg_o = SEG_R;
      default: sseg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display_scan.sv
// rtl/calc_display_scan.sv - 4-digit multiplexed display of calculator sign/tens/units or blinking "Err"
module calc_display_scan
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] result,
  input  logic       neg,
  input  logic       valid,
  output logic [6:0] sseg,
  output logic [3:0] an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_t            slot_q, slot_d;
  logic [3:0]       mag_q, mag_d;
  logic             neg_q, neg_d;
  logic             valid_q, valid_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             phase_q, phase_d;
  logic [6:0]       sseg_q, sseg_d;
  logic [3:0]       an_q, an_d;

  logic       tick;
  logic       capture;
  logic [3:0] units;
  glyph_e     glyph;
  logic [6:0] glyph_seg;

  always_comb begin
    tick    = (cnt_q == CNT_LAST);
    capture = tick && (slot_q == 2'd3);
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    slot_d  = tick ? slot_t'(slot_q + 2'd1) : slot_q;
    mag_d   = capture ? result : mag_q;
    neg_d   = capture ? neg    : neg_q;
    valid_d = capture ? valid  : valid_q;

    // A fresh overflow restarts the blink so "Err" always opens visible
    blk_d   = blk_q;
    phase_d = phase_q;
    if (valid_d || (capture && valid_q)) begin
      blk_d   = '0;
      phase_d = 1'b1;
    end else if (tick) begin
      if (blk_q == BLK_LAST) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + BLK_W'(1);
      end
    end

    units = (mag_d >= 4'd10) ? mag_d - 4'd10 : mag_d;
    glyph = BLANK;
    if (valid_d) begin
      case (slot_d)
        2'd0:    glyph = glyph_e'(units);
        2'd1:    glyph = (mag_d >= 4'd10) ? DIG1 : BLANK;
        2'd2:    glyph = neg_d ? MINUS : BLANK;
        default: glyph = BLANK;
      endcase
    end else if (phase_d) begin
      case (slot_d)
        2'd0, 2'd1: glyph = R;
        2'd2:       glyph = E;
        default:    glyph = BLANK;
      endcase
    end

    // Outputs only move on a tick, which keeps the display dark after reset until the first capture
    sseg_d = sseg_q;
    an_d   = an_q;
    if (tick) begin
      sseg_d = glyph_seg;
      an_d   = (glyph == BLANK) ? 4'b1111 : ~(4'b0001 << slot_d);
    end
  end

  calc_glyph_rom u_glyph_rom (
    .glyph_i (glyph),
    .sseg_o  (glyph_seg)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      slot_q  <= 2'd0;
      mag_q   <= 4'd0;
      neg_q   <= 1'b0;
      valid_q <= 1'b1;
      blk_q   <= '0;
      phase_q <= 1'b1;
      sseg_q  <= SEG_BLANK;
      an_q    <= 4'b1111;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      valid_q <= valid_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      sseg_q  <= sseg_d;
      an_q    <= an_d;
    end
  end

  assign sseg = sseg_q;
  assign an   = an_q;

endmodule

// File: doc/calc_display_scan.md
Name: calc_display_scan

Overview:
- Downstream display stage for the 4-bit add/subtract calculator. It consumes the calculator's corrected result magnitude, sign flag and validity flag.
- Drives the time-multiplexed 4-digit seven-segment display: sign digit, tens digit and units digit in decimal, or a blinking "Err" when the result is invalid.
- All outputs are registered. Inputs are captured once per display frame, so the digits never tear mid-scan.

Parameters:
- REFRESH_DIV, 100000, CLK cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 2 and up.
- BLINK_DIV, 500, refresh ticks per half-period of the "Err" blink; legal range 1 and up.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset, asynchronous, active-high.
- result  in  4  unsigned magnitude from the calculator, 0..15.
- neg  in  1  1 = result is negative; show '-'.
- valid  in  1  1 = result in range; 0 = overflow, show "Err".
- sseg  out  7  segments, active-low; bit0 = a ... bit6 = g.
- an  out  4  anodes, active-low; an[0] is the rightmost digit.

Behaviour:
- Reset (asynchronous, while RST=1):
  - an=4'b1111, sseg=7'b1111111.
  - Refresh counter, slot index and blink counter all 0.
  - Blink phase = on.
  - Captured state: mag=0, neg=0, valid=1.
- Refresh tick: the counter runs 0..REFRESH_DIV-1. The tick is the single cycle where the counter equals REFRESH_DIV-1. On each tick the slot index advances 0→1→2→3→0.
- Frame capture: on the tick where the index wraps from 3 to 0, register result, neg and valid. These are the captured values. Input changes at any other time are ignored until the next wrap.
- Digit mapping (from captured state, valid=1):
  - slot0: units = mag mod 10.
  - slot1: tens = 1 when mag ≥ 10, else blank (leading-zero blanking).
  - slot2: '-' when neg=1, else blank.
  - slot3: always blank.
  - mag=0 shows "0"; neg with mag=0 still shows "-0" (no sign suppression).
- Digit mapping, valid=0:
  - slot2 = 'E', slot1 = 'r', slot0 = 'r', slot3 blank.
  - While the blink phase is off, all slots are blank.
- Blank slot: the an bit is high and sseg=7'b1111111.
- Active slot: only its an bit is low; all other an bits are high.
- Output latency: sseg/an reflect the new slot exactly 1 CLK after the tick cycle.
- Glyphs, as {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - '-'=0111111, 'E'=0000110, 'r'=0101111, blank=1111111.
- Blink:
  - The blink counter counts refresh ticks only while captured valid=0. The phase toggles every BLINK_DIV ticks.
  - When captured valid goes 1→0 at a frame capture, the counter clears and the phase is forced on, so "Err" always starts visible.
  - While captured valid=1, the counter is held at 0 and the phase is on.
- Simultaneous events: a tick that coincides with a frame capture uses the newly captured values for slot0 of the new frame.
- Reset mid-scan: immediate return to the reset state; the first capture happens at the first 3→0 wrap after release.

Decomposition:
- Shared package calc_disp_pkg holds:
  - the glyph typedef (enum: DIG0..DIG9, MINUS, E, R, BLANK);
  - the 7-bit segment constants listed above;
  - the 2-bit slot index typedef.
- One combinational sub-module, calc_glyph_rom: glyph in → active-low sseg out. It is also reused by future display blocks.
- The top level holds the refresh counter, slot index, capture registers, blink logic and glyph select.

Test Plan (REFRESH_DIV=4, BLINK_DIV=2):
- Reset, release, result=4'd13, neg=0, valid=1.
  - After the first capture: slot0 gives an=1110, sseg=0110000 ('3').
  - slot1 gives an=1101, sseg=1111001 ('1').
  - slot2 and slot3 give an=1111.
- result=4'd7, neg=1, valid=1.
  - slot0 = '7' (1111000).
  - slot1 is blank, an=1111.
  - slot2 gives an=1011, sseg=0111111.
- Inputs change in the middle of slot1 → the old digits persist until the 3→0 wrap; the new value appears at slot0 one cycle after the wrap tick.
- valid drops to 0 → the frame shows E/r/r on an[2..0].
  - After 2 ticks the phase is off: an=1111 for 2 ticks.
  - Then on again. First frame after the drop is visible.
- Tick spacing check: an changes exactly 4 CLK apart, each change 1 CLK after the tick cycle; never more than one an bit low.
- Assert RST mid-slot2 → an=1111 and sseg=1111111 in the same cycle (async). After release, the display stays blank until the first capture.
